// File: rtl/aes_pkg.sv
// Shared AES definitions: key-size encoding, round counts and controller states.
// Reused by the round controller and the cipher/key-expansion datapath blocks.
package aes_pkg;

  typedef enum logic [1:0] {
    KeyAes128 = 2'b00,
    KeyAes192 = 2'b01,
    KeyAes256 = 2'b10,
    KeyRsvd   = 2'b11
  } key_size_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StLoad  = 2'b01,
    StRound = 2'b10,
    StHold  = 2'b11
  } ctrl_state_e;

  // The reserved encoding falls back to AES-128.
  function automatic logic [3:0] nr_of(key_size_e ks);
    case (ks)
      KeyAes192: return NR_192;
      KeyAes256: return NR_256;
      default:   return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// AES round counter: counts up to Nr and saturates, flagging Nr-1 and Nr.
module aes_round_cnt
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_inc,
  input  logic [3:0] i_nr,
  output logic [3:0] o_cnt,
  output logic       o_at_last_m1,
  output logic       o_at_last
);

  logic [3:0] r_cnt;
  logic       w_at_last;

  assign w_at_last = (r_cnt == i_nr);

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= 4'd0;
    end else if (i_inc && !w_at_last) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_cnt        = r_cnt;
  assign o_at_last    = w_at_last;
  assign o_at_last_m1 = (r_cnt == i_nr - 4'd1);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: IDLE -> LOAD -> ROUND x (Nr+1) -> HOLD.
// Define AES_WIDEKEY_EN to enable 192/256-bit keys; otherwise Nr is fixed at 10.
module aes_round_ctrl
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [1:0] key_size,
  output logic       core_reset,
  output logic       core_done,
  output logic [3:0] round_idx,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  ctrl_state_e r_state;
  ctrl_state_e w_state_next;
  logic        w_start_hs;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic [3:0]  w_nr;
  logic [3:0]  w_cnt;
  logic        w_at_last_m1;
  logic        w_at_last;

  assign w_start_hs = start_valid && start_ready;

`ifdef AES_WIDEKEY_EN
  key_size_e r_key_size;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_size <= KeyAes128;
    end else if (w_start_hs) begin
      r_key_size <= key_size_e'(key_size);
    end
  end

  assign w_nr = nr_of(r_key_size);
`else
  logic w_unused_key_size;
  assign w_unused_key_size = ^key_size;
  assign w_nr              = NR_128;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_start_hs) w_state_next = StLoad;
      end
      StLoad: begin
        w_cnt_clr    = 1'b1;
        w_state_next = StRound;
      end
      StRound: begin
        w_cnt_inc = 1'b1;
        if (w_at_last) w_state_next = StHold;
      end
      StHold: begin
        if (out_ready) begin
          w_cnt_clr    = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  aes_round_cnt u_round_cnt (
    .clk          (clk),
    .reset        (reset),
    .i_clr        (w_cnt_clr),
    .i_inc        (w_cnt_inc),
    .i_nr         (w_nr),
    .o_cnt        (w_cnt),
    .o_at_last_m1 (w_at_last_m1),
    .o_at_last    (w_at_last)
  );

  // Outputs are forced to their reset values for the whole time reset is high,
  // including the first cycle before the synchronous reset has taken effect.
  assign start_ready = !reset && (r_state == StIdle);
  assign busy        = !reset && (r_state != StIdle);
  assign core_reset  = reset || (r_state == StLoad);
  assign core_done   = !reset && (r_state == StRound) && w_at_last_m1;
  assign out_valid   = !reset && (r_state == StHold);
  assign round_idx   = reset ? 4'd0 : w_cnt;

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have clk, input, 1, system clock.
REQ-002 SHALL have reset, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have start_valid, input, 1, requester offers a new block.
REQ-004 SHALL have start_ready, output, 1, controller accepts a block.
REQ-005 SHALL have key_size, input, 2, key length: 00=128, 01=192, 10=256, 11=reserved; sampled on start handshake.
REQ-006 SHALL have core_reset, output, 1, restart pulse to cipher and key-expansion datapath.
REQ-007 SHALL have core_done, output, 1, last-round flag to cipher datapath.
REQ-008 SHALL have round_idx, output, 4, current round number 0..Nr.
REQ-009 SHALL have out_valid, output, 1, ciphertext on datapath output is final.
REQ-010 SHALL have out_ready, input, 1, consumer accepts ciphertext.
REQ-011 SHALL have busy, output, 1, high in every state except IDLE.

Function
REQ-012 SHALL use Nr=10/12/14 for key_size 00/01/10; reserved 11 SHALL be treated as 00.
REQ-013 SHALL implement states IDLE, LOAD, ROUND, HOLD.
REQ-014 IDLE: start_ready=1; start_valid&start_ready SHALL latch key_size, then go to LOAD next cycle.
REQ-015 start_ready SHALL be 0 in LOAD, ROUND and HOLD; start_valid there SHALL be ignored.
REQ-016 LOAD: core_reset=1 for exactly one cycle, round_idx=0, then go to ROUND.
REQ-017 ROUND: round_idx SHALL start at 0 and increment by 1 each cycle; core_reset=0.
REQ-018 core_done SHALL be 1 only in the ROUND cycle with round_idx==Nr-1, so the datapath runs Nr+1 round cycles (initial key add plus Nr rounds).
REQ-019 After the ROUND cycle with round_idx==Nr, go to HOLD with round_idx held at Nr.
REQ-020 HOLD: out_valid=1; out_valid&out_ready SHALL return to IDLE next cycle and clear round_idx to 0.
REQ-021 out_valid SHALL be 0 in every other state; out_ready outside HOLD SHALL be ignored.
REQ-022 Start-to-out_valid latency SHALL be Nr+3 cycles after the handshake cycle: 13/15/17 cycles.
REQ-023 A new start SHALL be accepted no earlier than the cycle after the HOLD handshake cycle; IDLE-HOLD overlap SHALL NOT occur.
REQ-024 The latched key_size SHALL NOT change until the next accepted start.
REQ-025 Any illegal state encoding SHALL return to IDLE on the next cycle.

Reset
REQ-026 While reset=1, the state SHALL be IDLE, and round_idx=0, latched key_size=00, core_reset=1, core_done=0, out_valid=0, start_ready=0, busy=0.
REQ-027 Reset asserted mid-operation (LOAD/ROUND/HOLD) SHALL abandon the block with no out_valid pulse; the first cycle after reset deasserts SHALL be IDLE with start_ready=1.

Configuration
REQ-028 Macro AES_WIDEKEY_EN defined: 192/256-bit support per REQ-012.
REQ-029 Macro AES_WIDEKEY_EN undefined: key_size SHALL be ignored and Nr SHALL be fixed at 10; the Nr selection logic SHALL be compiled out.

Structure
REQ-030 The following SHALL reside in shared package aes_pkg, for reuse by datapath blocks: key-size enum, Nr constants (10/12/14), and the controller state enum.
REQ-031 The round counter with terminal-count compares (Nr-1, Nr) SHALL be a single sub-module aes_round_cnt; all else SHALL be inline in aes_round_ctrl.

Verification
REQ-032 128-bit: start with key_size=00, out_ready=1 -> core_reset for 1 cycle, core_done at round_idx=9, out_valid 13 cycles after the handshake, busy low next cycle.
REQ-033 256-bit (macro on): start with key_size=10 -> core_done at round_idx=13, out_valid latency 17; key_size=11 -> behaves exactly as 00.
REQ-034 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid and round_idx=Nr held; start_valid=1 ignored with start_ready=0; released on out_ready=1.
REQ-035 Reset at round_idx=5 -> no out_valid; IDLE with start_ready=1 on the first cycle after reset; a new 192-bit start completes with latency 15.
REQ-036 Macro off: start with key_size=10 -> Nr=10, latency 13.
REQ-037 Back-to-back: start_valid held high -> a second handshake occurs one cycle after the first HOLD handshake, and key_size is resampled.
